lsu_mem_initiator: RTL
======================

// Module: lsu_mem_initiator
// PURPOSE
// - Load/store initiator for the RV32I core's word-addressed data memory. The memory has a combinational
//   read, a write on the clock edge, and accepts aligned word writes only.
// - Turns core LB/LH/LW/LBU/LHU/SB/SH/SW requests into memory cycles: extracts and extends load data,
//   performs read-modify-write for SB/SH, and reports misaligned or illegal accesses.
// - Sits between the execute stage (valid/ready request and response) and the data memory ports.
// PARAMETERS
// - ADDR_W  32  byte-address width for request and memory address
// PORTS
// - clk              in   1   clock; all state updates on posedge
// - rst_en           in   1   reset, asynchronous, active-high
// - req_valid        in   1   core request valid
// - req_ready        out  1   high only in IDLE; a request is accepted when req_valid && req_ready
// - req_write        in   1   1=store, 0=load
// - req_funct3       in   3   RV32I funct3 (0=B 1=H 2=W 4=BU 5=HU)
// - req_addr         in   32  byte address
// - req_wdata        in   32  store data; the low byte or halfword is used for SB/SH
// - rsp_valid        out  1   response valid; held until rsp_ready
// - rsp_ready        in   1   core accepts the response
// - rsp_rdata        out  32  extended load data; 0 for stores and errors
// - rsp_error        out  1   misaligned address or illegal funct3
// - mem_address      out  32  always {addr_q[31:2],2'b00}
// - mem_write_data   out  32  full word to be written
// - mem_write_enable out  1   decoded from the state register only, so it is glitch-free
// - mem_read_data    in   32  combinational read data for mem_address
// BEHAVIOUR
// - States: IDLE, ACCESS, RMW_WR, RESP. Reset puts the block in IDLE with all registers cleared.
// - Outputs in reset: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, mem_write_enable=0,
//   mem_address=0, mem_write_data=0.
// - IDLE: on accept, latch addr, funct3, wdata, write.
//   - Illegal access goes straight to RESP with rsp_error=1 and no memory cycle. Illegal means:
//     H/HU/SH with addr[0]=1; W with addr[1:0]!=0; load funct3 in {3,6,7}; store funct3 >= 3.
//   - Any other request goes to ACCESS.
// - ACCESS:
//   - Load: capture the extracted mem_read_data into rsp_rdata -> RESP.
//   - SW: mem_write_enable=1, mem_write_data=wdata -> RESP.
//   - SB/SH: capture the merged word (old word with the new lane(s) replaced) -> RMW_WR. No write in this cycle.
// - RMW_WR: mem_write_enable=1, mem_write_data=merged word -> RESP.
// - RESP: rsp_valid=1. On rsp_ready -> IDLE; otherwise hold rsp_valid, rsp_rdata and rsp_error stable.
// - Latency from accept edge to rsp_valid: load/SW 2 cycles; SB/SH 3 cycles; error 1 cycle.
// - Back-to-back: the next request can be accepted 1 cycle after the rsp handshake. No overlap.
// - Lanes are little-endian.
//   - Byte lane = addr[1:0]; halfword lane = addr[1].
//   - LB/LH sign-extend; LBU/LHU zero-extend.
// - mem_write_enable is high for exactly one cycle per store and never for a load or an error.
// - Reset mid-operation: state returns to IDLE asynchronously and mem_write_enable drops immediately.
//   - A store interrupted in ACCESS or RMW_WR is lost; the pending response is discarded.
// - rsp_valid rises only from a state edge. It never depends combinationally on req_valid.
// STRUCTURE
// - Package lsu_pkg holds:
//   - typedef enum logic [2:0] for funct3 (LS_B, LS_H, LS_W, LS_BU, LS_HU);
//   - typedef enum logic [1:0] for lsu_state_t;
//   - function is_legal(write, funct3, addr[1:0]).
// - Sub-module lsu_align (purely combinational) does two things:
//   - load extract/extend: word, funct3, lane -> rdata;
//   - store merge: old word, wdata, funct3, lane -> merged word.
// - The top level holds the FSM, the request registers and the response registers.
// TESTING
// - SW addr 0x10 data 0xDEADBEEF, then LW 0x10:
//   - one write-enable pulse with mem_address=0x10;
//   - load returns rdata=0xDEADBEEF, error=0, rsp_valid 2 cycles after accept.
// - Word 0x10 holds 0x11223344; SB addr 0x12 data 0x000000AA:
//   - exactly one mem_write_enable cycle, in RMW_WR, with mem_write_data=0x11AA3344;
//   - rsp_valid 3 cycles after accept.
// - Word 0x8 holds 0x80F0_7F81:
//   - LB 0x8 -> 0xFFFFFF81; LBU 0x8 -> 0x00000081;
//   - LH 0xA -> 0xFFFF80F0; LHU 0xA -> 0x000080F0.
// - Error cases, each with rsp_error=1, rdata=0, zero write-enable cycles, rsp_valid 1 cycle after accept:
//   - LW 0x6;
//   - SH 0x5;
//   - load funct3=3.
// - Hold rsp_ready=0 for 5 cycles:
//   - rsp_valid/rsp_rdata stay stable and req_ready stays 0;
//   - after the handshake, the next request is accepted 1 cycle later.
// - Assert rst_en while in RMW_WR of an SH:
//   - mem_write_enable drops the same cycle and the target word is unchanged;
//   - after release: req_ready=1, rsp_valid=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and the access-legality rule for the load/store initiator.
package lsu_pkg;

  typedef enum logic [2:0] {
    LS_B  = 3'd0,
    LS_H  = 3'd1,
    LS_W  = 3'd2,
    LS_BU = 3'd4,
    LS_HU = 3'd5
  } ls_funct3_t;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StRmwWr,
    StResp
  } lsu_state_t;

  // Stores only exist for B/H/W; halfwords need addr[0]=0, words addr[1:0]=0.
  function automatic logic is_legal(input logic write, input logic [2:0] funct3,
                                    input logic [1:0] lane);
    logic ok;
    ok = 1'b0;
    case (funct3)
      LS_B:    ok = 1'b1;
      LS_H:    ok = !lane[0];
      LS_W:    ok = (lane == 2'b00);
      LS_BU:   ok = !write;
      LS_HU:   ok = !write && !lane[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: load extract/extend and store read-modify-write merge (little-endian).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    rdata    = '0;
    merged   = word;

    case (funct3)
      LS_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
      LS_BU:   rdata = {24'b0, byte_sel};
      LS_H:    rdata = {{16{half_sel[15]}}, half_sel};
      LS_HU:   rdata = {16'b0, half_sel};
      LS_W:    rdata = word;
      default: rdata = '0;
    endcase

    case (funct3)
      LS_B: merged[{lane, 3'b000} +: 8] = wdata[7:0];
      LS_H: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      LS_W:    merged = wdata;
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: turns core requests into single-word memory cycles,
// with read-modify-write for sub-word stores.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_en,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_write_enable,
  input  logic [31:0]       mem_read_data
);

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [31:0]       wdata_q;
  logic              write_q;
  logic [31:0]       rdata_q;
  logic              error_q;
  logic [31:0]       merged_q;

  logic [31:0] load_data;
  logic [31:0] merged_data;
  logic        req_legal;
  logic        is_sub_word_store;

  lsu_align u_align (
    .word   (mem_read_data),
    .funct3 (funct3_q),
    .lane   (addr_q[1:0]),
    .wdata  (wdata_q),
    .rdata  (load_data),
    .merged (merged_data)
  );

  assign req_legal         = is_legal(req_write, req_funct3, req_addr[1:0]);
  assign is_sub_word_store = write_q && (funct3_q != LS_W);
  assign mem_address       = {addr_q[ADDR_W-1:2], 2'b00};
  assign rsp_rdata         = rdata_q;
  assign rsp_error         = error_q;

  always_comb begin
    state_d          = state_q;
    req_ready        = 1'b0;
    rsp_valid        = 1'b0;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_legal ? StAccess : StResp;
      end
      StAccess: begin
        if (write_q && !is_sub_word_store) begin
          mem_write_enable = 1'b1;
          mem_write_data   = wdata_q;
        end
        state_d = is_sub_word_store ? StRmwWr : StResp;
      end
      StRmwWr: begin
        mem_write_enable = 1'b1;
        mem_write_data   = merged_q;
        state_d          = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst_en) begin
    if (rst_en) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
      merged_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            wdata_q  <= req_wdata;
            write_q  <= req_write;
            rdata_q  <= '0;
            error_q  <= !req_legal;
          end
        end
        StAccess: begin
          if (!write_q) rdata_q  <= load_data;
          else          merged_q <= merged_data;
        end
        default: ;
      endcase
    end
  end

endmodule
